// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer: debounced one-hot keypad to 7-segment digit buffer with cursor and commit.
module keypad_entry_buffer #(
    parameter int NUM_DIGITS      = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WRAP_CURSOR     = 1,
    localparam int CW = $clog2(NUM_DIGITS),
    localparam int NW = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             Keypad_in,
    output logic                    key_valid,
    output logic [3:0]              key_code,
    output logic [CW-1:0]           cursor,
    output logic                    full,
    output logic [7*NUM_DIGITS-1:0] disp_buf,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    out_valid
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t                  state_q, state_d;
    logic [11:0]             kp_q, cand_q, cand_d;
    logic [NW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           cursor_q, cursor_d;
    logic [3:0]              key_code_q, key_code_d, code_c;
    logic [7*NUM_DIGITS-1:0] disp_q, disp_d, seg_q, seg_d;
    logic                    key_valid_q, out_valid_q, ev, key_ok, done, at_last;

    function automatic logic [6:0] seg7(input logic [3:0] c);
        case (c)
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110010;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            4'd0:    return 7'b1111110;
            default: return 7'b0000000;
        endcase
    endfunction

    assign key_ok  = (kp_q != '0) && ((kp_q & (kp_q - 12'd1)) == '0);
    assign done    = cnt_q >= NW'(DEBOUNCE_CYCLES);
    assign at_last = cursor_q == CW'(NUM_DIGITS - 1);

    always_comb begin
        code_c = 4'd0;
        for (int i = 0; i < 12; i++)
            if (cand_q[i]) code_c = (i == 9) ? 4'd0 : (i < 9) ? 4'(i + 1) : 4'(i);
    end

    // Debounce counts consecutive identical samples; the event fires on the sample after the count is met.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        ev      = 1'b0;
        case (state_q)
            IDLE: if (key_ok) begin
                state_d = DEBOUNCE;
                cand_d  = kp_q;
                cnt_d   = NW'(1);
            end
            DEBOUNCE: if (kp_q == cand_q) begin
                if (done) begin
                    ev      = 1'b1;
                    state_d = PRESSED;
                end else cnt_d = cnt_q + NW'(1);
            end else if (key_ok) begin
                cand_d = kp_q;
                cnt_d  = NW'(1);
            end else state_d = IDLE;
            PRESSED: if (kp_q == '0) begin
                state_d = RELEASE;
                cnt_d   = NW'(1);
            end
            RELEASE: if (kp_q != '0) state_d = PRESSED;
                     else if (done) state_d = IDLE;
                     else cnt_d = cnt_q + NW'(1);
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_code_d = ev ? code_c : key_code_q;
        cursor_d   = cursor_q;
        disp_d     = disp_q;
        seg_d      = seg_q;
        if (ev && code_c < 4'd10) disp_d[7*int'(cursor_q) +: 7] = seg7(code_c);
        if (ev && code_c == 4'd11)
            cursor_d = at_last ? ((WRAP_CURSOR != 0) ? '0 : cursor_q) : cursor_q + CW'(1);
        if (ev && code_c == 4'd10) begin
            seg_d    = disp_q;
            disp_d   = '0;
            cursor_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            kp_q        <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            cursor_q    <= '0;
            key_code_q  <= '0;
            disp_q      <= '0;
            seg_q       <= '0;
            key_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kp_q        <= Keypad_in;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            cursor_q    <= cursor_d;
            key_code_q  <= key_code_d;
            disp_q      <= disp_d;
            seg_q       <= seg_d;
            key_valid_q <= ev;
            out_valid_q <= ev && code_c == 4'd10;
        end
    end

    assign key_valid = key_valid_q;
    assign out_valid = out_valid_q;
    assign key_code  = key_code_q;
    assign cursor    = cursor_q;
    assign disp_buf  = disp_q;
    assign seg_out   = seg_q;
    assign full      = (WRAP_CURSOR == 0) && at_last;
endmodule

// File: tb/tb_keypad_entry_buffer.sv
// tb_keypad_entry_buffer: directed checks of debounce, entry, commit, cursor boundaries and reset.
module tb_keypad_entry_buffer;
    logic clk = 1'b0, rst = 1'b1;
    logic [11:0] kp = '0;
    logic kv8, full8, ov8, kvw, fullw, ovw, kvs, fulls, ovs;
    logic [3:0] kc8, kcw, kcs;
    logic [2:0] cur8;
    logic [1:0] curw, curs;
    logic [55:0] disp8, seg8;
    logic [27:0] dispw, segw, disps, segs;
    int n_chk = 0, n_err = 0;

    localparam logic [11:0] K1 = 12'h001, K2 = 12'h002, K3 = 12'h004, K5 = 12'h010,
                            K7 = 12'h040, K8 = 12'h080, K9 = 12'h100, K0 = 12'h200,
                            KS = 12'h400, KH = 12'h800;
    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001,
                           S5 = 7'b1011011, S7 = 7'b1110010, S8 = 7'b1111111, S9 = 7'b1111011;

    always #5 clk = ~clk;

    keypad_entry_buffer #(.NUM_DIGITS(8), .DEBOUNCE_CYCLES(4), .WRAP_CURSOR(1)) dut (
        .clk(clk), .rst(rst), .Keypad_in(kp), .key_valid(kv8), .key_code(kc8), .cursor(cur8),
        .full(full8), .disp_buf(disp8), .seg_out(seg8), .out_valid(ov8));
    keypad_entry_buffer #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .WRAP_CURSOR(1)) dut_w (
        .clk(clk), .rst(rst), .Keypad_in(kp), .key_valid(kvw), .key_code(kcw), .cursor(curw),
        .full(fullw), .disp_buf(dispw), .seg_out(segw), .out_valid(ovw));
    keypad_entry_buffer #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .WRAP_CURSOR(0)) dut_s (
        .clk(clk), .rst(rst), .Keypad_in(kp), .key_valid(kvs), .key_code(kcs), .cursor(curs),
        .full(fulls), .disp_buf(disps), .seg_out(segs), .out_valid(ovs));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edge 0 is the first edge that samples k; first reports the edge index of the first key_valid.
    task automatic hold(input logic [11:0] k, input int n, output int first, output int kvn, output int ovn);
        kp = k;
        first = -1;
        kvn = 0;
        ovn = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (kv8) begin
                if (first < 0) first = i;
                kvn++;
            end
            if (ov8) ovn++;
        end
    endtask

    task automatic release_key();
        kp = '0;
        repeat (12) step();
    endtask

    task automatic press(input string tag, input logic [11:0] k);
        int f, a, b;
        hold(k, 8, f, a, b);
        chk(tag, a, 1);
        release_key();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_kv"}, kv8, 0);
        chk({tag, "_ov"}, ov8, 0);
        chk({tag, "_code"}, kc8, 0);
        chk({tag, "_cursor"}, cur8, 0);
        chk({tag, "_disp"}, disp8, 0);
        chk({tag, "_seg"}, seg8, 0);
        chk({tag, "_full"}, fulls, 0);
    endtask

    initial begin
        int f, a, b, cnt;
        repeat (2) step();
        chk_reset("reset");
        rst = 1'b0;

        hold(K5, 20, f, a, b);
        chk("lat5", f, 5);
        chk("once5", a, 1);
        chk("code5", kc8, 5);
        chk("dig0_5", disp8[6:0], S5);
        chk("cur_after5", cur8, 0);
        release_key();

        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            kp = (i % 4 < 2) ? K3 : 12'h000;
            step();
            if (kv8) cnt++;
        end
        chk("bounce_quiet", cnt, 0);
        // Final stable run began at loop edge 8, so the event lands 5 edges later: hold edge 3.
        hold(K3, 10, f, a, b);
        chk("bounce_lat", f, 3);
        chk("bounce_once", a, 1);
        chk("dig0_3", disp8[6:0], S3);
        release_key();

        hold(12'h003, 20, f, a, b);
        chk("multihot_none", a, 0);
        chk("multihot_disp", disp8[6:0], S3);
        chk("multihot_code", kc8, 3);
        release_key();

        hold(KS, 8, f, a, b);
        chk("commit1_ov", b, 1);
        chk("commit1_seg", seg8, {49'b0, S3});
        chk("commit1_disp", disp8, 0);
        chk("commit1_code", kc8, 10);
        release_key();

        press("p1", K1);
        press("ph1", KH);
        press("p2", K2);
        press("ph2", KH);
        press("p0", K0);
        chk("entry_disp", disp8[20:0], {S0, S2, S1});
        chk("entry_cur", cur8, 2);
        hold(KS, 8, f, a, b);
        chk("entry_kv", a, 1);
        chk("entry_ov", b, 1);
        chk("entry_seg", seg8, {35'b0, S0, S2, S1});
        chk("entry_disp_clr", disp8, 0);
        chk("entry_cur0", cur8, 0);
        release_key();

        repeat (3) press("hash", KH);
        chk("wrap_cur3", curw, 3);
        chk("sat_cur3", curs, 3);
        chk("sat_full3", fulls, 1);
        chk("wrap_full", fullw, 0);
        press("hash4", KH);
        chk("wrap_cur0", curw, 0);
        chk("sat_cur4", curs, 3);
        press("hash5", KH);
        chk("sat_cur5", curs, 3);
        chk("sat_full5", fulls, 1);
        chk("cur8_5", cur8, 5);
        press("clr", KS);
        chk("clr_full", fulls, 0);

        press("p7", K7);
        chk("ovw_7", disp8[6:0], S7);
        press("p9", K9);
        chk("ovw_9", disp8[6:0], S9);
        chk("ovw_cur", cur8, 0);

        kp = K8;
        step();
        step();
        rst = 1'b1;
        cnt = 0;
        repeat (2) begin
            step();
            if (kv8) cnt++;
        end
        chk("rst_mid_none", cnt, 0);
        chk_reset("rst_mid");
        rst = 1'b0;
        hold(K8, 8, f, a, b);
        chk("post_rst_lat", f, 5);
        chk("post_rst_once", a, 1);
        chk("post_rst_dig", disp8[6:0], S8);
        release_key();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/keypad_entry_buffer.md
# keypad_entry_buffer

Parametrised keypad-to-display entry unit: debounces the 12-key one-hot keypad, produces exactly one event per physical press, and assembles pressed digits into a NUM_DIGITS-deep 7-segment digit buffer under a cursor. '#' advances the cursor and '*' commits the buffer to the register-file/segment-controller path with a one-cycle valid strobe. It replaces the single-shot keypad scan and display pair, and sits between the keypad pins and the register file.

## Interface
- NUM_DIGITS, 8, digit buffer depth (≥2); CW = $clog2(NUM_DIGITS)
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required for press and for release (≥1)
- WRAP_CURSOR, 1, 1: '#' at last digit wraps to 0; 0: saturates at NUM_DIGITS-1
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- Keypad_in  in  12  one-hot keys: bit0..bit8 = '1'..'9', bit9 = '0', bit10 = '*', bit11 = '#'
- key_valid  out  1  one-cycle pulse per debounced press
- key_code  out  4  code of last press: 1–9, 0 for '0', 10 '*', 11 '#'
- cursor  out  CW  current write position
- full  out  1  cursor == NUM_DIGITS-1 and WRAP_CURSOR == 0
- disp_buf  out  7*NUM_DIGITS  live buffer; digit i at [7i+6:7i]
- seg_out  out  7*NUM_DIGITS  committed buffer, same packing
- out_valid  out  1  one-cycle pulse when seg_out updates

## Operation
- Input registered once (kp_q) before any decision; no logic acts on raw Keypad_in.
- Valid key: kp_q has exactly one bit set. Zero or multi-hot is "no key"; multi-hot never produces an event.
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE.
  - IDLE: valid key in kp_q -> DEBOUNCE, latch candidate, count = 1.
  - DEBOUNCE: kp_q == candidate -> count+1; count reaches DEBOUNCE_CYCLES -> emit event, go to PRESSED. kp_q is a different valid key -> restart with new candidate, count = 1. No key -> IDLE.
  - PRESSED: kp_q nonzero -> stay (held key yields no repeat). kp_q zero -> RELEASE, count = 1.
  - RELEASE: zero for DEBOUNCE_CYCLES consecutive cycles -> IDLE. Any nonzero -> PRESSED.
- Event action, on the same edge that raises key_valid:
  - Digit key: digit[cursor] <= code; cursor unchanged (overwrite).
  - '#': cursor+1. At NUM_DIGITS-1, wrap to 0 if WRAP_CURSOR, else hold.
  - '*': seg_out <= disp_buf (pre-clear value); out_valid = 1; buffer cleared to blank; cursor <= 0.
- Segment codes, {a,b,c,d,e,f,g}, active-high:
  - 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011, 5 = 1011011
  - 6 = 1011111, 7 = 1110010, 8 = 1111111, 9 = 1111011, 0 = 1111110
  - blank = 0000000
- key_code holds its last value between events.

## Timing
- Reset (rst high at an edge): FSM IDLE, count 0, cursor 0, disp_buf and seg_out all blank, key_valid 0, out_valid 0, key_code 0, full 0. rst overrides any same-edge event.
- Latency: key K held continuously from before edge 0 (the first edge sampling K into kp_q) -> key_valid high after edge DEBOUNCE_CYCLES+1. Buffer, cursor and seg_out visibly updated after that same edge.
- key_valid and out_valid are exactly one cycle wide. out_valid coincides with key_valid for '*'.
- Minimum press-to-press spacing is 2·DEBOUNCE_CYCLES+2 cycles. Shorter activity merges or is filtered; no event is lost mid-state.
- Reset mid-DEBOUNCE: no event. A key still held after reset restarts debounce from IDLE.
- Commit with an empty buffer is legal: seg_out becomes all blank and out_valid pulses.
- full is combinational from cursor and the parameter; there is no extra latency.

## Test plan
- Reset, DEBOUNCE_CYCLES=4: hold '5' (bit4) 20 cycles -> single key_valid after edge 5, key_code=5, digit0=1011011, cursor 0; no repeat while held.
- Bounce: '3' toggling every 2 cycles for 10 cycles, then stable -> exactly one event, 5 edges after the final stable sample; multi-hot 0x003 held -> no event.
- Entry: '1', '#', '2', '#', '0', '*' -> seg_out[20:0] = {1111110,1101101,0110000}, upper digits blank, out_valid one cycle, disp_buf blank, cursor 0.
- Cursor boundary, NUM_DIGITS=4: WRAP_CURSOR=1, 4×'#' -> cursor 3->0. WRAP_CURSOR=0, 5×'#' -> cursor 3, full=1.
- Overwrite: '7' then '9' without '#' -> digit0 = 1111011.
- rst asserted 2 cycles into a debounced '8' -> no key_valid, all outputs at reset values.
